// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit; runs a req/ack bus cycle for loads/stores and stalls until ack.
// Optional ALIGN_CHECK_EN: misaligned accesses raise exc_adel_o/exc_ades_o instead of a bus cycle.
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        exc_adel_o,
  output logic        exc_ades_o
);
  localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
  localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
  localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
  localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
  localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
  localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP  = 8'b11101011;
  localparam logic [4:0] NOPRegAddr = 5'b00000;
  localparam logic       Stop       = 1'b1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t r_state, w_next;

  logic        r_req, r_we;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_sel;
  logic        w_ld, w_st, w_byte, w_half, w_misal, w_issue, w_unused;
  logic [3:0]  w_sel;
  logic [31:0] w_swdata, w_bsh, w_hsh, w_ldata;

  assign w_ld   = aluop_i inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  assign w_st   = aluop_i inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  assign w_byte = aluop_i inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP};
  assign w_half = aluop_i inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP};
`ifdef ALIGN_CHECK_EN
  assign w_misal = (w_half & mem_addr_i[0]) |
                   ((aluop_i == EXE_LW_OP || aluop_i == EXE_SW_OP) & |mem_addr_i[1:0]);
`else
  assign w_misal = 1'b0;
`endif
  assign w_issue  = (w_ld | w_st) & ~w_misal;
  assign w_unused = ^{stall[5], stall[3:0]};

  // Big-endian lanes: lowest address maps to the most significant byte.
  assign w_sel    = w_byte ? 4'b1000 >> mem_addr_i[1:0] :
                    w_half ? (mem_addr_i[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  assign w_swdata = w_byte ? {4{reg2_i[7:0]}} : w_half ? {2{reg2_i[15:0]}} : reg2_i;

  // ex_mem holds the instruction through DONE, so the live address picks the lane.
  assign w_bsh   = r_rdata << {mem_addr_i[1:0], 3'b000};
  assign w_hsh   = r_rdata << {mem_addr_i[1], 4'b0000};
  assign w_ldata = aluop_i == EXE_LB_OP  ? {{24{w_bsh[31]}}, w_bsh[31:24]} :
                   aluop_i == EXE_LBU_OP ? {24'h0, w_bsh[31:24]} :
                   aluop_i == EXE_LH_OP  ? {{16{w_hsh[31]}}, w_hsh[31:16]} :
                   aluop_i == EXE_LHU_OP ? {16'h0, w_hsh[31:16]} : r_rdata;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_issue ? BUSY : IDLE;
      BUSY:    w_next = bus_ack_i ? DONE : BUSY;
      DONE:    w_next = (stall[4] == Stop) ? DONE : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'h0;
      r_sel   <= 4'h0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_issue) begin
        r_req   <= 1'b1;
        r_we    <= w_st;
        r_addr  <= {mem_addr_i[31:2], 2'b00};
        r_sel   <= w_sel;
        r_wdata <= w_swdata;
      end else if (r_state == BUSY && bus_ack_i) begin
        r_req   <= 1'b0;
        r_rdata <= bus_rdata_i;
      end
    end
  end

  always_comb begin
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = wdata_i;
    stallreq_o = 1'b0;
    exc_adel_o = 1'b0;
    exc_ades_o = 1'b0;
    if (rst) begin
      wd_o    = NOPRegAddr;
      wreg_o  = 1'b0;
      wdata_o = 32'h0;
    end else if (r_state == IDLE) begin
      stallreq_o = w_issue;
      wreg_o     = (w_ld | w_st) ? 1'b0 : wreg_i;
      exc_adel_o = w_ld & w_misal;
      exc_ades_o = w_st & w_misal;
    end else if (r_state == BUSY) begin
      stallreq_o = 1'b1;
      wreg_o     = 1'b0;
    end else begin
      wreg_o  = w_ld ? wreg_i : 1'b0;
      wdata_o = w_ld ? w_ldata : wdata_i;
    end
  end

  assign bus_req_o   = r_req;
  assign bus_we_o    = r_we;
  assign bus_addr_o  = r_addr;
  assign bus_sel_o   = r_sel;
  assign bus_wdata_o = r_wdata;
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for mem_lsu with hand-computed expectations.
module tb_mem_lsu;
  localparam logic [7:0] LB  = 8'b11100000;
  localparam logic [7:0] LHU = 8'b11100101;
  localparam logic [7:0] LW  = 8'b11100011;
  localparam logic [7:0] SB  = 8'b11101000;
  localparam logic [7:0] OR  = 8'b00100101;

  logic        clk = 0, rst = 1;
  logic [5:0]  stall = 0;
  logic [4:0]  wd_i = 0;
  logic        wreg_i = 0;
  logic [31:0] wdata_i = 0, mem_addr_i = 0, reg2_i = 0, bus_rdata_i = 0;
  logic [7:0]  aluop_i = 0;
  logic        bus_ack_i = 0;
  logic [4:0]  wd_o;
  logic        wreg_o, stallreq_o, bus_req_o, bus_we_o, exc_adel_o, exc_ades_o;
  logic [31:0] wdata_o, bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_sel_o;
  int total = 0, bad = 0, n;

  mem_lsu dut (
    .clk(clk), .rst(rst), .stall(stall), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .stallreq_o(stallreq_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .exc_adel_o(exc_adel_o), .exc_ades_o(exc_ades_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [7:0] a, input logic [4:0] d, input logic w,
                    input logic [31:0] wd, input logic [31:0] ad, input logic [31:0] r2);
    aluop_i = a; wd_i = d; wreg_i = w; wdata_i = wd; mem_addr_i = ad; reg2_i = r2;
    #1;
  endtask

  initial begin
    op(LW, 5'd7, 1, 32'h55, 32'h100, 0);
    tick; tick;
    chk("rst_req", bus_req_o, 0);
    chk("rst_wd", wd_o, 0);
    chk("rst_wreg", wreg_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_stall", stallreq_o, 0);
    chk("rst_sel", bus_sel_o, 0);
    op(OR, 5'd3, 1, 32'h1234, 0, 0);
    rst = 0;
    tick;
    chk("or_wd", wd_o, 3);
    chk("or_wreg", wreg_o, 1);
    chk("or_wdata", wdata_o, 32'h1234);
    chk("or_stall", stallreq_o, 0);

    op(LB, 5'd5, 1, 0, 32'h101, 0);
    chk("lb_idle_stall", stallreq_o, 1);
    chk("lb_idle_wreg", wreg_o, 0);
    n = 0;
    tick; n++;
    chk("lb_req", bus_req_o, 1);
    chk("lb_sel", bus_sel_o, 4'b0100);
    chk("lb_we", bus_we_o, 0);
    chk("lb_addr", bus_addr_o, 32'h100);
    while (stallreq_o && n < 20) begin
      if (n == 3) begin bus_ack_i = 1; bus_rdata_i = 32'h11F23344; end
      tick; n++;
      bus_ack_i = 0;
    end
    chk("lb_stall_cycles", n, 4);
    chk("lb_wreg", wreg_o, 1);
    chk("lb_wd", wd_o, 5);
    chk("lb_data", wdata_o, 32'hFFFFFFF2);
    chk("lb_req_drop", bus_req_o, 0);
    tick;
    op(OR, 5'd1, 0, 32'h9, 0, 0);

    op(LHU, 5'd6, 1, 0, 32'h102, 0);
    tick;
    chk("lhu_sel", bus_sel_o, 4'b0011);
    bus_ack_i = 1; bus_rdata_i = 32'hAAAA8001;
    tick;
    bus_ack_i = 0;
    chk("lhu_data", wdata_o, 32'h00008001);
    chk("lhu_wreg", wreg_o, 1);
    chk("lhu_stall", stallreq_o, 0);
    tick;
    op(OR, 5'd1, 0, 32'h9, 0, 0);
    chk("lhu_wreg_once", wreg_o, 0);

    op(SB, 5'd8, 1, 0, 32'h203, 32'h000000A5);
    tick;
    chk("sb_we", bus_we_o, 1);
    chk("sb_sel", bus_sel_o, 4'b0001);
    chk("sb_wdata", bus_wdata_o, 32'hA5A5A5A5);
    chk("sb_addr", bus_addr_o, 32'h200);
    bus_ack_i = 1;
    tick;
    bus_ack_i = 0;
    chk("sb_done_wreg", wreg_o, 0);
    chk("sb_done_stall", stallreq_o, 0);
    stall = 6'b010000;
    tick;
    chk("sb_hold_wreg", wreg_o, 0);
    chk("sb_hold_noreq", bus_req_o, 0);
    stall = 0;
    tick;
    op(OR, 5'd2, 1, 32'h77, 0, 0);
    chk("sb_back_idle", wreg_o, 1);

    op(LW, 5'd9, 1, 0, 32'h102, 0);
`ifdef ALIGN_CHECK_EN
    chk("lw_mis_adel", exc_adel_o, 1);
    chk("lw_mis_stall", stallreq_o, 0);
    chk("lw_mis_wreg", wreg_o, 0);
    tick;
    op(OR, 5'd2, 1, 32'h77, 0, 0);
    chk("lw_mis_noreq", bus_req_o, 0);
    chk("lw_mis_once", exc_adel_o, 0);
`else
    chk("lw_noexc", exc_adel_o, 0);
    tick;
    chk("lw_addr", bus_addr_o, 32'h100);
    chk("lw_sel", bus_sel_o, 4'b1111);
    bus_ack_i = 1; bus_rdata_i = 32'hDEADBEEF;
    tick;
    bus_ack_i = 0;
    chk("lw_data", wdata_o, 32'hDEADBEEF);
    tick;
    op(OR, 5'd2, 1, 32'h77, 0, 0);
`endif

    op(LW, 5'd4, 1, 0, 32'h300, 0);
    tick;
    chk("rb_req", bus_req_o, 1);
    rst = 1;
    tick; tick;
    chk("rb_req_drop", bus_req_o, 0);
    chk("rb_wreg", wreg_o, 0);
    op(OR, 5'd2, 1, 32'h77, 0, 0);
    rst = 0;
    bus_ack_i = 1; bus_rdata_i = 32'h12345678;
    tick;
    bus_ack_i = 0;
    chk("rb_late_ack_req", bus_req_o, 0);
    chk("rb_late_ack_stall", stallreq_o, 0);
    chk("rb_idle_pass", wdata_o, 32'h77);
    tick;
    chk("rb_still_idle", stallreq_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
